// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around mem_port_arbiter.
// master: the arbiter's view; slave: the requesters' and memory's view.
interface mem_port_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            if_req_v_i;
  logic [XLEN-1:0] if_adr_i;
  logic            if_gnt_o;
  logic            if_rsp_v_o;
  logic [XLEN-1:0] if_rdata_o;
  logic            flush_i;

  logic            ls_req_v_i;
  logic [XLEN-1:0] ls_adr_i;
  logic            ls_is_store_i;
  logic [XLEN-1:0] ls_wdata_i;
  logic [2:0]      ls_size_i;
  logic            ls_gnt_o;
  logic            ls_rsp_v_o;
  logic [XLEN-1:0] ls_rdata_o;

  logic            mem_req_v_o;
  logic [XLEN-1:0] mem_adr_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [2:0]      mem_size_o;
  logic            mem_gnt_i;
  logic            mem_rsp_v_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    input  if_req_v_i, if_adr_i, flush_i,
    input  ls_req_v_i, ls_adr_i, ls_is_store_i, ls_wdata_i, ls_size_i,
    input  mem_gnt_i, mem_rsp_v_i, mem_rdata_i,
    output if_gnt_o, if_rsp_v_o, if_rdata_o,
    output ls_gnt_o, ls_rsp_v_o, ls_rdata_o,
    output mem_req_v_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o
  );

  modport slave (
    output if_req_v_i, if_adr_i, flush_i,
    output ls_req_v_i, ls_adr_i, ls_is_store_i, ls_wdata_i, ls_size_i,
    output mem_gnt_i, mem_rsp_v_i, mem_rdata_i,
    input  if_gnt_o, if_rsp_v_o, if_rdata_o,
    input  ls_gnt_o, ls_rsp_v_o, ls_rdata_o,
    input  mem_req_v_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: LS has priority,
// IF wins after STARVE_MAX consecutive LS grants. One outstanding transaction.
module mem_port_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                clk,
  input logic                reset_n,
  mem_port_arbiter_if.master bus
);
  localparam int unsigned CNT_W     = $clog2(STARVE_MAX + 1);
  localparam logic [2:0]  SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_WAIT} state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;

  typedef struct packed {
    logic [XLEN-1:0] adr;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic [2:0]      size;
  } mem_req_t;

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             rst_done_q;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             drop_q, drop_d;
  logic             store_q;

  logic     if_req, ls_req, starved;
  logic     req_v, rsp_take, gnt, if_gnt, ls_gnt, if_rsp, ls_rsp;
  mem_req_t req_pl;

  // Requests are ignored until the first clock edge after reset release.
  assign if_req  = bus.if_req_v_i & rst_done_q;
  assign ls_req  = bus.ls_req_v_i & rst_done_q;
  assign starved = (starve_q == CNT_W'(STARVE_MAX));

  // Next state, current owner and issue/response qualifiers.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    req_v    = 1'b0;
    rsp_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (if_req | ls_req) begin
          req_v   = 1'b1;
          owner_d = (if_req & (starved | ~ls_req)) ? OWN_IF : OWN_LS;
          state_d = bus.mem_gnt_i ? ST_WAIT : ST_HOLD;
        end
      end
      ST_HOLD: begin
        req_v = 1'b1;
        if (bus.mem_gnt_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rsp_v_i) begin
          rsp_take = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request payload from the owner; all fields zero when nothing is presented.
  always_comb begin
    req_pl = '0;
    if (req_v) begin
      if (owner_d == OWN_IF) begin
        req_pl.adr  = bus.if_adr_i;
        req_pl.size = SIZE_WORD;
      end else begin
        req_pl.adr   = bus.ls_adr_i;
        req_pl.we    = bus.ls_is_store_i;
        req_pl.wdata = bus.ls_wdata_i;
        req_pl.size  = bus.ls_size_i;
      end
    end
  end

  assign gnt    = bus.mem_gnt_i & req_v;
  assign if_gnt = gnt & (owner_d == OWN_IF);
  assign ls_gnt = gnt & (owner_d == OWN_LS);
  assign if_rsp = rsp_take & (owner_q == OWN_IF) & ~(drop_q | bus.flush_i);
  assign ls_rsp = rsp_take & (owner_q == OWN_LS);

  assign bus.mem_req_v_o = req_v;
  assign bus.mem_adr_o   = req_pl.adr;
  assign bus.mem_we_o    = req_pl.we;
  assign bus.mem_wdata_o = req_pl.wdata;
  assign bus.mem_size_o  = req_pl.size;
  assign bus.if_gnt_o    = if_gnt;
  assign bus.ls_gnt_o    = ls_gnt;
  assign bus.if_rsp_v_o  = if_rsp;
  assign bus.if_rdata_o  = if_rsp ? bus.mem_rdata_i : '0;
  assign bus.ls_rsp_v_o  = ls_rsp;
  assign bus.ls_rdata_o  = (ls_rsp & ~store_q) ? bus.mem_rdata_i : '0;

  // Starvation counter and fetch-drop flag.
  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req_v_i || if_gnt) begin
      starve_d = '0;
    end else if (ls_gnt && !starved) begin
      starve_d = starve_q + CNT_W'(1);
    end

    drop_d = drop_q;
    if (rsp_take && (owner_q == OWN_IF)) begin
      drop_d = 1'b0;
    end else if (bus.flush_i &&
                 (((owner_d == OWN_IF) && (state_q != ST_IDLE)) || if_gnt)) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      rst_done_q <= 1'b0;
      starve_q   <= '0;
      drop_q     <= 1'b0;
      store_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rst_done_q <= 1'b1;
      starve_q   <= starve_d;
      drop_q     <= drop_d;
      if (gnt) store_q <= req_pl.we;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int unsigned XLEN       = 32;
  localparam int          STARVE_MAX = 4;
  localparam int          N_RAND     = 3000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.XLEN(XLEN)) bus ();
  mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Stimulus applied by cycle()
  logic            rst_v, if_req, flush, ls_req, ls_st, mgnt, mrsp;
  logic [XLEN-1:0] if_adr, ls_adr, ls_wd, mrdata;
  logic [2:0]      ls_sz;

  // Model: ready after reset, pending owner (-1 none, 0 IF, 1 LS), busy transaction
  bit m_ready, m_busy, m_drop, m_store;
  int m_pend, m_own, m_starve;

  logic            e_if_gnt, e_ls_gnt;
  logic            o_mem_req, o_we, o_if_gnt, o_ls_gnt, o_if_rsp, o_ls_rsp;
  logic [XLEN-1:0] o_adr, o_wdata, o_if_rdata, o_ls_rdata;
  logic [2:0]      o_size;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, predict, compare, advance model at the edge.
  task automatic cycle();
    logic            ifr, lsr, e_req, e_gnt, e_we, e_if_rsp, e_ls_rsp, take;
    logic [XLEN-1:0] e_adr, e_wd, e_if_rd, e_ls_rd;
    logic [2:0]      e_sz;
    int              own;
    reset_n           = rst_v;
    bus.if_req_v_i    = if_req;
    bus.if_adr_i      = if_adr;
    bus.flush_i       = flush;
    bus.ls_req_v_i    = ls_req;
    bus.ls_adr_i      = ls_adr;
    bus.ls_is_store_i = ls_st;
    bus.ls_wdata_i    = ls_wd;
    bus.ls_size_i     = ls_sz;
    bus.mem_gnt_i     = mgnt;
    bus.mem_rsp_v_i   = mrsp;
    bus.mem_rdata_i   = mrdata;
    if (!rst_v) begin
      m_ready = 0; m_busy = 0; m_drop = 0; m_store = 0;
      m_pend = -1; m_own = 0; m_starve = 0;
    end
    #2;
    ifr   = if_req & m_ready;
    lsr   = ls_req & m_ready;
    e_req = 1'b0;
    own   = m_own;
    if (m_busy) own = m_own;
    else if (m_pend >= 0) begin e_req = 1'b1; own = m_pend; end
    else if (ifr || lsr) begin
      e_req = 1'b1;
      own   = (ifr && (m_starve == STARVE_MAX || !lsr)) ? 0 : 1;
    end
    e_adr = '0; e_we = 1'b0; e_wd = '0; e_sz = '0;
    if (e_req && own == 0) begin e_adr = if_adr; e_sz = 3'b010; end
    else if (e_req) begin e_adr = ls_adr; e_we = ls_st; e_wd = ls_wd; e_sz = ls_sz; end
    e_gnt    = e_req & mgnt;
    e_if_gnt = e_gnt && own == 0;
    e_ls_gnt = e_gnt && own == 1;
    take     = m_busy & mrsp;
    e_if_rsp = take && own == 0 && !m_drop && !flush;
    e_ls_rsp = take && own == 1;
    e_if_rd  = e_if_rsp ? mrdata : '0;
    e_ls_rd  = (e_ls_rsp && !m_store) ? mrdata : '0;

    o_mem_req = bus.mem_req_v_o; o_adr = bus.mem_adr_o; o_we = bus.mem_we_o;
    o_wdata = bus.mem_wdata_o; o_size = bus.mem_size_o;
    o_if_gnt = bus.if_gnt_o; o_ls_gnt = bus.ls_gnt_o;
    o_if_rsp = bus.if_rsp_v_o; o_if_rdata = bus.if_rdata_o;
    o_ls_rsp = bus.ls_rsp_v_o; o_ls_rdata = bus.ls_rdata_o;

    check("mem_req_v", XLEN'(o_mem_req), XLEN'(e_req));
    check("mem_adr",   o_adr,            e_adr);
    check("mem_we",    XLEN'(o_we),      XLEN'(e_we));
    check("mem_wdata", o_wdata,          e_wd);
    check("mem_size",  XLEN'(o_size),    XLEN'(e_sz));
    check("if_gnt",    XLEN'(o_if_gnt),  XLEN'(e_if_gnt));
    check("ls_gnt",    XLEN'(o_ls_gnt),  XLEN'(e_ls_gnt));
    check("if_rsp_v",  XLEN'(o_if_rsp),  XLEN'(e_if_rsp));
    check("if_rdata",  o_if_rdata,       e_if_rd);
    check("ls_rsp_v",  XLEN'(o_ls_rsp),  XLEN'(e_ls_rsp));
    check("ls_rdata",  o_ls_rdata,       e_ls_rd);

    @(posedge clk);
    if (rst_v) begin
      if (!ifr || e_if_gnt) m_starve = 0;
      else if (e_ls_gnt && m_starve < STARVE_MAX) m_starve++;
      if (take && own == 0) m_drop = 0;
      else if (flush && own == 0 && (m_busy || m_pend >= 0 || e_if_gnt)) m_drop = 1;
      if (take) m_busy = 0;
      if (e_gnt) begin
        m_busy = 1; m_own = own; m_store = (own == 1) && ls_st; m_pend = -1;
      end else if (e_req) begin
        m_pend = own;
      end
      m_ready = 1;
    end
    #1;
  endtask

  initial begin
    int ls_before_if;
    bit if_seen;
    int cd;
    rst_v = 0; if_req = 0; flush = 0; ls_req = 0; ls_st = 0; mgnt = 0; mrsp = 0;
    if_adr = '0; ls_adr = '0; ls_wd = '0; mrdata = '0; ls_sz = '0;
    reset_n = 1'b1;
    #1;

    // Reset: IF request held during reset and the first masked cycle
    if_req = 1; if_adr = 32'h100;
    cycle();
    check("rst_mem_req", XLEN'(o_mem_req), XLEN'(0));
    cycle();
    rst_v = 1;
    cycle();
    check("mask_mem_req", XLEN'(o_mem_req), XLEN'(0));

    // 1: IF-only, granted same cycle, response two cycles later
    mgnt = 1;
    cycle();
    check("t1_if_gnt", XLEN'(o_if_gnt), XLEN'(1));
    check("t1_adr", o_adr, 32'h100);
    check("t1_size", XLEN'(o_size), XLEN'(3'b010));
    if_req = 0; mgnt = 0;
    cycle();
    mrsp = 1; mrdata = 32'hDEADBEEF;
    cycle();
    check("t1_if_rsp", XLEN'(o_if_rsp), XLEN'(1));
    check("t1_if_rdata", o_if_rdata, 32'hDEADBEEF);
    check("t1_ls_rsp", XLEN'(o_ls_rsp), XLEN'(0));
    mrsp = 0;

    // 2: simultaneous IF and LS load -> LS first, IF right after the LS response
    if_req = 1; if_adr = 32'h104;
    ls_req = 1; ls_adr = 32'h2000; ls_st = 0; ls_sz = 3'b010; mgnt = 1;
    cycle();
    check("t2_ls_gnt", XLEN'(o_ls_gnt), XLEN'(1));
    check("t2_if_gnt", XLEN'(o_if_gnt), XLEN'(0));
    check("t2_we", XLEN'(o_we), XLEN'(0));
    ls_req = 0;
    cycle();
    mrsp = 1; mrdata = 32'hA5A5_0001;
    cycle();
    check("t2_ls_rdata", o_ls_rdata, 32'hA5A5_0001);
    mrsp = 0;
    cycle();
    check("t2_if_gnt_after", XLEN'(o_if_gnt), XLEN'(1));
    if_req = 0;
    mrsp = 1; mrdata = 32'h0000_0104;
    cycle();
    mrsp = 0;

    // 3: starvation guard with both requesters always pending
    if_req = 1; ls_req = 1; ls_st = 0; mgnt = 1;
    ls_before_if = 0; if_seen = 0;
    for (int it = 0; it < 6; it++) begin
      ls_adr = 32'h3000 + 32'(it * 4);
      if_adr = 32'h200 + 32'(it * 4);
      mrsp = 0;
      cycle();
      if (o_if_gnt) if_seen = 1;
      if (o_ls_gnt && !if_seen) ls_before_if++;
      if (it == 4) check("t3_if_wins", XLEN'(o_if_gnt), XLEN'(1));
      else check("t3_ls_wins", XLEN'(o_ls_gnt), XLEN'(1));
      mrsp = 1; mrdata = $urandom();
      cycle();
    end
    check("t3_ls_count", XLEN'(ls_before_if), XLEN'(STARVE_MAX));
    if_req = 0; ls_req = 0; mrsp = 0;
    cycle();

    // 4: store stalled three cycles while IF arrives
    ls_req = 1; ls_st = 1; ls_adr = 32'h4000; ls_wd = 32'h12345678; ls_sz = 3'b010; mgnt = 0;
    cycle();
    if_req = 1; if_adr = 32'h300;
    for (int s = 0; s < 2; s++) begin
      cycle();
      check("t4_stall_wdata", o_wdata, 32'h12345678);
      check("t4_stall_adr", o_adr, 32'h4000);
      check("t4_stall_if_gnt", XLEN'(o_if_gnt), XLEN'(0));
    end
    mgnt = 1;
    cycle();
    check("t4_ls_gnt", XLEN'(o_ls_gnt), XLEN'(1));
    ls_req = 0;
    mrsp = 1; mrdata = 32'hFFFF_FFFF;
    cycle();
    check("t4_store_ack", XLEN'(o_ls_rsp), XLEN'(1));
    check("t4_store_rdata", o_ls_rdata, 32'h0);
    mrsp = 0;
    cycle();
    check("t4_if_gnt", XLEN'(o_if_gnt), XLEN'(1));
    if_req = 0; mrsp = 1;
    cycle();
    mrsp = 0;

    // 5: flush while the fetch waits drops that response only
    if_req = 1; if_adr = 32'h400; mgnt = 1;
    cycle();
    if_req = 0; flush = 1;
    cycle();
    flush = 0; mrsp = 1; mrdata = 32'h1111_1111;
    cycle();
    check("t5_dropped_v", XLEN'(o_if_rsp), XLEN'(0));
    check("t5_dropped_d", o_if_rdata, 32'h0);
    mrsp = 0; if_req = 1; if_adr = 32'h404;
    cycle();
    if_req = 0; mrsp = 1; mrdata = 32'h2222_2222;
    cycle();
    check("t5_next_v", XLEN'(o_if_rsp), XLEN'(1));
    check("t5_next_d", o_if_rdata, 32'h2222_2222);
    mrsp = 0;

    // 6: reset during WAIT, late response ignored
    if_req = 1; if_adr = 32'h500;
    cycle();
    if_req = 0;
    cycle();
    rst_v = 0; mrsp = 1; if_req = 1;
    cycle();
    check("t6_rst_mem_req", XLEN'(o_mem_req), XLEN'(0));
    check("t6_rst_if_rsp", XLEN'(o_if_rsp), XLEN'(0));
    rst_v = 1;
    cycle();
    check("t6_late_rsp", XLEN'(o_if_rsp), XLEN'(0));
    mrsp = 0;
    cycle();
    if_req = 0; mrsp = 1;
    cycle();
    mrsp = 0;
    cycle();

    // Random traffic against the model
    cd = 0; if_req = 0; ls_req = 0;
    for (int n = 0; n < N_RAND; n++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1; if_adr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!ls_req && $urandom_range(0, 2) != 0) begin
        ls_req = 1; ls_adr = $urandom(); ls_st = 1'($urandom_range(0, 1));
        ls_wd = $urandom(); ls_sz = 3'($urandom_range(0, 2));
      end
      mgnt   = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 7) == 0);
      mrdata = $urandom();
      if (cd > 0) begin cd--; mrsp = (cd == 0); end
      else mrsp = ($urandom_range(0, 7) == 0);
      cycle();
      if (e_if_gnt) if_req = 0;
      if (e_ls_gnt) ls_req = 0;
      if (e_if_gnt || e_ls_gnt) cd = $urandom_range(1, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
